bcd_addsub_datapath: RTL

- Parametrised, digit-serial BCD add/subtract datapath with a four-phase req/ack command interface.
- Holds operand registers A and B of DIGITS packed-BCD digits each.
- Computes A+B or |A−B| one digit per clock, then drives A, B or the result onto output_value on command.
- Driven by the lab controller FSM; output_value feeds the display path.

---
 rtl/bcd_addsub_datapath.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/bcd_addsub_datapath.sv
`default_nettype none
// ============================================================================
// Module      : bcd_addsub_datapath
// Description : Digit-serial packed-BCD add / magnitude-subtract datapath with
//               operand registers A and B, a result register R and a
//               four-phase req/ack command interface. The registered
//               output_value feeds the display path.
// Revision    : 1.0  initial release
// ============================================================================
module bcd_addsub_datapath #(
    parameter int DIGITS = 2,
    parameter int OUT_W  = 4*(DIGITS+1)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [4*DIGITS-1:0]   input_value,
    input  logic                  mode,
    input  logic                  init,
    input  logic                  load_a,
    input  logic                  load_b,
    input  logic                  compute,
    input  logic                  display_a,
    input  logic                  display_b,
    input  logic                  display_result,
    output logic                  init_ack,
    output logic                  load_a_ack,
    output logic                  load_b_ack,
    output logic                  compute_ack,
    output logic                  display_a_ack,
    output logic                  display_b_ack,
    output logic                  display_result_ack,
    output logic [OUT_W-1:0]      output_value,
    output logic                  negative,
    output logic                  bcd_err,
    output logic                  busy
);

    localparam int DW    = 4*DIGITS;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS-1);

    // Command indices double as bit positions in the request/ack vectors;
    // a lower index has higher priority.
    localparam logic [2:0] CMD_INIT    = 3'd0;
    localparam logic [2:0] CMD_LOAD_A  = 3'd1;
    localparam logic [2:0] CMD_LOAD_B  = 3'd2;
    localparam logic [2:0] CMD_COMPUTE = 3'd3;
    localparam logic [2:0] CMD_DISP_A  = 3'd4;
    localparam logic [2:0] CMD_DISP_B  = 3'd5;
    localparam logic [2:0] CMD_DISP_R  = 3'd6;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EXEC   = 3'd1,
        ADD    = 3'd2,
        RECOMP = 3'd3,
        ACK    = 3'd4
    } state_t;

    state_t            state;
    logic [2:0]        cmd;
    logic [DW-1:0]     a_reg;
    logic [DW-1:0]     b_reg;
    logic [DW-1:0]     r_reg;
    logic              carry;      // final carry nibble bit shown by display_result
    logic              dc;         // running digit carry
    logic              sub_mode;
    logic [CNT_W-1:0]  cnt;
    logic [6:0]        acks;

    logic [6:0]        reqs;
    logic              req_any;
    logic [2:0]        req_idx;

    logic [CNT_W+1:0]  dig_off;
    logic [3:0]        a_dig;
    logic [3:0]        b_dig;
    logic [3:0]        r_dig;
    logic [3:0]        op_a;
    logic [3:0]        op_b_raw;
    logic [3:0]        op_b;
    logic [4:0]        sum_bin;
    logic [4:0]        sum_adj;
    logic [3:0]        sum_dig;
    logic              cout;

    assign reqs = {display_result, display_b, display_a, compute, load_b, load_a, init};

    assign init_ack           = acks[0];
    assign load_a_ack         = acks[1];
    assign load_b_ack         = acks[2];
    assign compute_ack        = acks[3];
    assign display_a_ack      = acks[4];
    assign display_b_ack      = acks[5];
    assign display_result_ack = acks[6];

    assign busy = (state == ADD) || (state == RECOMP);

    // True when every nibble of the operand is a legal BCD digit.
    function automatic logic all_bcd(input logic [DW-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // Fixed-priority arbiter: the lowest set request index wins.
    always_comb begin
        req_any = |reqs;
        req_idx = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (reqs[i]) req_idx = 3'(i);
        end
    end

    // One BCD digit adder, shared by the ADD pass and the ten's-complement
    // pass (RECOMP adds the nine's complement of R to zero with carry-in 1).
    always_comb begin
        dig_off  = {cnt, 2'b00};
        a_dig    = a_reg[dig_off +: 4];
        b_dig    = b_reg[dig_off +: 4];
        r_dig    = r_reg[dig_off +: 4];
        op_a     = (state == RECOMP) ? 4'd0 : a_dig;
        op_b_raw = (state == RECOMP) ? r_dig : b_dig;
        op_b     = (sub_mode || (state == RECOMP)) ? (4'd9 - op_b_raw) : op_b_raw;
        sum_bin  = {1'b0, op_a} + {1'b0, op_b} + {4'b0000, dc};
        sum_adj  = sum_bin + 5'd6;
        if (sum_bin > 5'd9) begin
            sum_dig = sum_adj[3:0];
            cout    = 1'b1;
        end else begin
            sum_dig = sum_bin[3:0];
            cout    = 1'b0;
        end
    end

    // Control FSM and all datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cmd          <= CMD_INIT;
            a_reg        <= '0;
            b_reg        <= '0;
            r_reg        <= '0;
            carry        <= 1'b0;
            dc           <= 1'b0;
            sub_mode     <= 1'b0;
            cnt          <= '0;
            acks         <= '0;
            output_value <= '0;
            negative     <= 1'b0;
            bcd_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        cmd   <= req_idx;
                        state <= EXEC;
                        if (req_idx == CMD_COMPUTE) sub_mode <= mode;
                    end
                end

                EXEC: begin
                    if (cmd == CMD_COMPUTE) begin
                        dc    <= sub_mode;
                        cnt   <= '0;
                        state <= ADD;
                    end else begin
                        acks  <= 7'b1 << cmd;
                        state <= ACK;
                        case (cmd)
                            CMD_INIT: begin
                                a_reg        <= '0;
                                b_reg        <= '0;
                                r_reg        <= '0;
                                carry        <= 1'b0;
                                negative     <= 1'b0;
                                bcd_err      <= 1'b0;
                                output_value <= '0;
                            end
                            CMD_LOAD_A: begin
                                if (all_bcd(input_value)) a_reg <= input_value;
                                else                      bcd_err <= 1'b1;
                            end
                            CMD_LOAD_B: begin
                                if (all_bcd(input_value)) b_reg <= input_value;
                                else                      bcd_err <= 1'b1;
                            end
                            CMD_DISP_A: output_value <= {4'h0, a_reg};
                            CMD_DISP_B: output_value <= {4'h0, b_reg};
                            CMD_DISP_R: output_value <= {3'b000, carry, r_reg};
                            default: ;
                        endcase
                    end
                end

                ADD: begin
                    r_reg[dig_off +: 4] <= sum_dig;
                    dc                  <= cout;
                    cnt                 <= cnt + 1'b1;
                    if (cnt == LAST_DIGIT) begin
                        cnt <= '0;
                        if (!sub_mode) begin
                            carry <= cout;
                            acks  <= 7'b1 << cmd;
                            state <= ACK;
                        end else if (cout) begin
                            carry    <= 1'b0;
                            negative <= 1'b0;
                            acks     <= 7'b1 << cmd;
                            state    <= ACK;
                        end else begin
                            // A < B: R holds 10^DIGITS - (B - A), so a
                            // ten's complement recovers the magnitude.
                            dc    <= 1'b1;
                            state <= RECOMP;
                        end
                    end
                end

                RECOMP: begin
                    r_reg[dig_off +: 4] <= sum_dig;
                    dc                  <= cout;
                    cnt                 <= cnt + 1'b1;
                    if (cnt == LAST_DIGIT) begin
                        cnt      <= '0;
                        carry    <= 1'b0;
                        negative <= 1'b1;
                        acks     <= 7'b1 << cmd;
                        state    <= ACK;
                    end
                end

                ACK: begin
                    if (!reqs[cmd]) begin
                        acks  <= '0;
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
